// File: rtl/gf211_pkg.sv
// Shared constants and FSM state type for the GF(211) Fermat inverter.
package gf211_pkg;

    localparam int unsigned Q         = 211;
    localparam int unsigned MU        = 310;
    localparam int unsigned EXP       = 209;
    localparam int unsigned BARRETT_K = 8;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned PROD_W    = 16;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

endpackage

// File: rtl/gf211_reduce.sv
// Combinational Barrett reducer: 16-bit product to residue mod 211.
// Exact for x <= 44100, the largest product the inverter can form (210*210).
module gf211_reduce
    import gf211_pkg::*;
(
    input  logic [PROD_W-1:0] x,
    output logic [DATA_W-1:0] r
);

    logic [PROD_W-1:0] t;
    logic [PROD_W-1:0] r0;
    logic [PROD_W-1:0] r1;

    always_comb begin
        // Quotient estimate; widened so q*MU cannot wrap.
        t  = PROD_W'((32'(x >> BARRETT_K) * MU) >> BARRETT_K);
        r0 = x - t * PROD_W'(Q);
        r1 = (r0 >= PROD_W'(Q)) ? r0 - PROD_W'(Q) : r0;
        r  = DATA_W'((r1 >= PROD_W'(Q)) ? r1 - PROD_W'(Q) : r1);
    end

endmodule

// File: rtl/gf211_inv.sv
// Modular inverse mod 211 via a^209, left-to-right square-and-multiply, one bit per cycle.
// Optional GF211_INV_RANGE_CHECK_EN rejects operands 0 and >=211 with err=1.
module gf211_inv
    import gf211_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] din_a,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dout_r,
    output logic              err
);

    localparam logic [DATA_W-1:0] ExpBits = DATA_W'(EXP);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, base_q, res_q;
    logic [2:0]        idx_q;
    logic [PROD_W-1:0] sq_prod, mul_prod;
    logic [DATA_W-1:0] sq_r, mul_r, acc_next, base_in;
    logic              bad;

    assign sq_prod  = PROD_W'(acc_q) * PROD_W'(acc_q);
    assign mul_prod = PROD_W'(sq_r) * PROD_W'(base_q);
    assign acc_next = ExpBits[idx_q] ? mul_r : sq_r;
    assign base_in  = (din_a >= DATA_W'(Q)) ? din_a - DATA_W'(Q) : din_a;

    gf211_reduce u_red_sq (
        .x (sq_prod),
        .r (sq_r)
    );

    gf211_reduce u_red_mul (
        .x (mul_prod),
        .r (mul_r)
    );

`ifdef GF211_INV_RANGE_CHECK_EN
    logic err_q;

    assign bad = (din_a == '0) || (din_a >= DATA_W'(Q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == StIdle && in_valid) begin
            err_q <= bad;
        end
    end
`else
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = bad ? StDone : StRun;
            StRun:   if (idx_q == 3'd0) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        dout_r    = res_q;
`ifdef GF211_INV_RANGE_CHECK_EN
        err       = err_q;
`else
        err       = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            base_q <= '0;
            idx_q  <= '0;
            res_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        base_q <= base_in;
                        acc_q  <= DATA_W'(1);
                        idx_q  <= 3'd7;
                        if (bad) res_q <= '0;
                    end
                end
                StRun: begin
                    acc_q <= acc_next;
                    idx_q <= idx_q - 3'd1;
                    if (idx_q == 3'd0) res_q <= acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf211_inv.sv
// Directed bench for gf211_inv and gf211_reduce; honours GF211_INV_RANGE_CHECK_EN.
module tb_gf211_inv;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din_a;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dout_r;
    logic       err;

    logic [15:0] red_x;
    logic [7:0]  red_r;

    int total = 0;
    int bad   = 0;

    gf211_inv dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_a     (din_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout_r    (dout_r),
        .err       (err)
    );

    gf211_reduce u_red (
        .x (red_x),
        .r (red_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operand, waits (bounded) for the result, consumes it.
    // Returns at #1 after the consume edge; lat counts edges after the accept edge.
    task automatic run_op(input logic [7:0] a, output logic [7:0] r, output logic e,
                          output int lat);
        @(negedge clk);
        din_a    = a;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = dout_r;
        e = err;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dout_r !== 8'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b dout_r=%0d err=%b want 1 0 0 0",
                     in_ready, out_valid, dout_r, err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || dout_r !== 8'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b dout_r=%0d err=%b want 1 0 0 0",
                     in_ready, out_valid, dout_r, err);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [4] = '{8'd2, 8'd3, 8'd1, 8'd210};
        logic [7:0] vr [4] = '{8'd106, 8'd141, 8'd1, 8'd210};
        logic [7:0] r;
        logic       e;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], r, e, lat);
            total++;
            if (r !== vr[i] || e !== 1'b0 || lat != 8) begin
                bad++;
                $display("FAIL vector a=%0d: got r=%0d err=%b lat=%0d want r=%0d err=0 lat=8",
                         va[i], r, e, lat, vr[i]);
            end
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL consume a=%0d: in_ready=%b out_valid=%b want 1 0",
                         va[i], in_ready, out_valid);
            end
        end
    endtask

    task automatic test_zero_and_range();
        logic [7:0] va [3] = '{8'd0, 8'd213, 8'd255};
`ifdef GF211_INV_RANGE_CHECK_EN
        logic [7:0] vr [3] = '{8'd0, 8'd0, 8'd0};
        logic       ve     = 1'b1;
        int         vl     = 0;
`else
        logic [7:0] vr [3] = '{8'd0, 8'd106, 8'd24};
        logic       ve     = 1'b0;
        int         vl     = 8;
`endif
        logic [7:0] r;
        logic       e;
        int         lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], r, e, lat);
            total++;
            if (r !== vr[i] || e !== ve || lat != vl) begin
                bad++;
                $display("FAIL range a=%0d: got r=%0d err=%b lat=%0d want r=%0d err=%b lat=%0d",
                         va[i], r, e, lat, vr[i], ve, vl);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat = 0;
        logic [7:0] r;
        logic       e;
        @(negedge clk);
        din_a    = 8'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++;
        if (lat != 8) begin
            bad++;
            $display("FAIL bp_latency: got %0d want 8", lat);
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                in_valid = 1'b1;
                din_a    = 8'd3;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || dout_r !== 8'd106 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold c=%0d: out_valid=%b dout_r=%0d in_ready=%b want 1 106 0",
                         c, out_valid, dout_r, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        run_op(8'd3, r, e, lat);
        total++;
        if (r !== 8'd141 || lat != 8) begin
            bad++;
            $display("FAIL bp_next: got r=%0d lat=%0d want r=141 lat=8", r, lat);
        end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] r;
        logic       e;
        int         lat;
        @(negedge clk);
        din_a    = 8'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrun_async: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrun_after: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        run_op(8'd3, r, e, lat);
        total++;
        if (r !== 8'd141 || e !== 1'b0 || lat != 8) begin
            bad++;
            $display("FAIL midrun_next: got r=%0d err=%b lat=%0d want 141 0 8", r, e, lat);
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] r;
        logic       e;
        int         lat;
        for (int a = 1; a <= 210; a++) begin
            run_op(8'(a), r, e, lat);
            total++;
            if (((a * int'(r)) % 211) != 1 || e !== 1'b0 || lat != 8) begin
                bad++;
                $display("FAIL exhaustive a=%0d: got r=%0d err=%b lat=%0d want a*r mod 211=1",
                         a, r, e, lat);
            end
        end
    endtask

    task automatic test_reduce_sweep();
        int nprint = 0;
        for (int x = 0; x <= 44100; x++) begin
            red_x = 16'(x);
            #1;
            total++;
            if (red_r !== 8'(x % 211)) begin
                bad++;
                if (nprint < 10) begin
                    $display("FAIL reduce x=%0d: got %0d want %0d", x, red_r, x % 211);
                    nprint++;
                end
            end
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din_a     = 8'd0;
        red_x     = 16'd0;
        test_reset();
        test_vectors();
        test_zero_and_range();
        test_backpressure();
        test_reset_midrun();
        test_exhaustive();
        test_reduce_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
